// File: rtl/siso_layer_scheduler.sv
// Read-side sequencer for the pipelined SISO row unit: walks every address of every layer
// for max_iter iterations and holds back reads whose previous-layer write-back is pending.
//
// state | meaning
// IDLE  | waiting for start, write-back tracking frozen
// RUN   | issuing reads, withholding any that hit the layer hazard
// DRAIN | all reads issued, waiting for the last write-backs
// DONE  | one-cycle completion pulse
module siso_layer_scheduler #(
  parameter int LAYERS    = 2,
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20,
  parameter int ITERBITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 wren_fb,
  input  logic                 wrlayer_fb,
  input  logic [ADDRWIDTH-1:0] wraddress_fb,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic [ITERBITS-1:0]  iter_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 stall,
  output logic                 seq_err
);

  localparam int PW = ITERBITS + 1;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic                 LAST_LAYER = 1'(LAYERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [ITERBITS-1:0]  max_r, max_eff, ptr_it, cur_it, nxt_it;
  logic                 ptr_ly, cur_ly, nxt_ly;
  logic [ADDRWIDTH-1:0] ptr_ad, cur_ad, nxt_ad;
  logic [ADDRWIDTH-1:0] wr_cnt, wr_cnt_nx;
  logic [PW-1:0]        done_passes, done_nx, pass, target;
  logic                 wr_hit, wr_err, allowed, issue, last_rd;

  always_comb begin
    // In IDLE the first read is decided from the pass-0 origin, so it issues on the start edge.
    max_eff = (state == IDLE) ? ((max_iter == '0) ? ITERBITS'(1) : max_iter) : max_r;
    cur_it  = (state == IDLE) ? '0 : ptr_it;
    cur_ly  = (state == IDLE) ? 1'b0 : ptr_ly;
    cur_ad  = (state == IDLE) ? '0 : ptr_ad;
    pass    = PW'(cur_it) * PW'(LAYERS) + PW'(cur_ly);
    target  = PW'(max_r) * PW'(LAYERS);

    wr_hit    = wren_fb && (state != IDLE);
    wr_err    = wr_hit && ((wraddress_fb != wr_cnt) ||
                           (wrlayer_fb != 1'(done_passes % PW'(LAYERS))));
    wr_cnt_nx = wr_cnt;
    done_nx   = done_passes;
    if (wr_hit) begin
      if (wr_cnt == LAST_ADDR) begin
        wr_cnt_nx = '0;
        done_nx   = done_passes + PW'(1);
      end else begin
        wr_cnt_nx = wr_cnt + ADDRWIDTH'(1);
      end
    end

    // Same-cycle write of the matching address counts as already written.
    allowed = (pass == '0) || (done_passes >= pass) ||
              ((done_passes == pass - PW'(1)) &&
               ((wr_cnt > cur_ad) || (wren_fb && (wraddress_fb == cur_ad))));
    issue   = (state == IDLE) ? start : ((state == RUN) && allowed);
    last_rd = (cur_ad == LAST_ADDR) && (cur_ly == LAST_LAYER) &&
              (cur_it == max_eff - ITERBITS'(1));

    nxt_ad = cur_ad + ADDRWIDTH'(1);
    nxt_ly = cur_ly;
    nxt_it = cur_it;
    if (cur_ad == LAST_ADDR) begin
      nxt_ad = '0;
      if (cur_ly == LAST_LAYER) begin
        nxt_ly = 1'b0;
        nxt_it = cur_it + ITERBITS'(1);
      end else begin
        nxt_ly = cur_ly + 1'b1;
      end
    end

    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = last_rd ? DRAIN : RUN;
      RUN:     if (issue && last_rd) state_nx = DRAIN;
      DRAIN:   if (done_nx == target) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rden_LLR    <= 1'b0;
      rden_E      <= 1'b0;
      rdlayer     <= 1'b0;
      rdaddress   <= '0;
      iter_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stall       <= 1'b0;
      seq_err     <= 1'b0;
      max_r       <= '0;
      ptr_it      <= '0;
      ptr_ly      <= 1'b0;
      ptr_ad      <= '0;
      wr_cnt      <= '0;
      done_passes <= '0;
    end else begin
      rden_LLR <= issue;
      rden_E   <= issue && (cur_it != '0);
      stall    <= (state == RUN) && !allowed;
      busy     <= (state_nx == RUN) || (state_nx == DRAIN);
      done     <= (state_nx == DONE);
      if (issue) begin
        rdlayer   <= cur_ly;
        rdaddress <= cur_ad;
        iter_cnt  <= cur_it;
        ptr_it    <= nxt_it;
        ptr_ly    <= nxt_ly;
        ptr_ad    <= nxt_ad;
      end
      if (state == IDLE) begin
        if (start) begin
          max_r       <= max_eff;
          wr_cnt      <= '0;
          done_passes <= '0;
        end
      end else begin
        wr_cnt      <= wr_cnt_nx;
        done_passes <= done_nx;
        if (wr_err) seq_err <= 1'b1;
      end
    end
  end

endmodule
